// File: rtl/deserializer_flex.sv
// Assembles LANE_WIDTH-bit beats into DATA_WIDTH-bit words in either beat order.
// Supports early flush of a partial word and a stallable valid/ready output register.
module deserializer_flex #(
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                                             clk_i,
  input  logic                                             arst_n_i,
  input  logic [LANE_WIDTH-1:0]                            data_i,
  input  logic                                             data_val_i,
  output logic                                             data_ready_o,
  input  logic                                             flush_i,
  output logic [DATA_WIDTH-1:0]                            deser_data_o,
  output logic [$clog2(DATA_WIDTH/LANE_WIDTH+1)-1:0]       deser_beats_o,
  output logic                                             deser_data_val_o,
  input  logic                                             deser_data_ready_i
);

  localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int BW    = $clog2(BEATS + 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [BW-1:0]         out_beats_q, out_beats_d;
  logic                  out_val_q, out_val_d;

  logic                  beat_acc_s;
  logic                  flush_acc_s;
  logic                  last_beat_s;
  logic                  emit_s;
  logic [CNT_W-1:0]      lane_s;
  logic [BW-1:0]         emit_beats_s;
  logic [DATA_WIDTH-1:0] acc_beat_s;

  // Physical lane for beat index k: reversed when the first beat is most significant.
  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] k);
    if (MSB_FIRST) begin
      return CNT_W'(BEATS - 1) - k;
    end else begin
      return k;
    end
  endfunction

  assign data_ready_o = !out_val_q || deser_data_ready_i;

  // Acceptance decode and the accumulator image including this cycle's beat.
  always_comb begin
    beat_acc_s   = data_val_i && data_ready_o;
    flush_acc_s  = flush_i && data_ready_o;
    last_beat_s  = (cnt_q == CNT_W'(BEATS - 1));
    lane_s       = lane_of(cnt_q);
    acc_beat_s   = acc_q;
    emit_s       = 1'b0;
    emit_beats_s = BW'(cnt_q);
    if (beat_acc_s) begin
      acc_beat_s[lane_s*LANE_WIDTH +: LANE_WIDTH] = data_i;
      emit_s       = last_beat_s || flush_acc_s;
      emit_beats_s = BW'(cnt_q) + BW'(1'b1);
    end else begin
      emit_s       = flush_acc_s && (cnt_q != {CNT_W{1'b0}});
      emit_beats_s = BW'(cnt_q);
    end
  end

  // Next-state: a new word may only load when the output register is free or being popped.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_val_d   = out_val_q;
    if (emit_s) begin
      out_data_d  = acc_beat_s;
      out_beats_d = emit_beats_s;
      out_val_d   = 1'b1;
      cnt_d       = {CNT_W{1'b0}};
      acc_d       = {DATA_WIDTH{1'b0}};
    end else begin
      if (beat_acc_s) begin
        acc_d = acc_beat_s;
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        acc_d = acc_q;
        cnt_d = cnt_q;
      end
      if (deser_data_ready_i) begin
        out_val_d = 1'b0;
      end else begin
        out_val_d = out_val_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q       <= {CNT_W{1'b0}};
      acc_q       <= {DATA_WIDTH{1'b0}};
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_beats_q <= {BW{1'b0}};
      out_val_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_val_q   <= out_val_d;
    end
  end

  assign deser_data_o     = out_data_q;
  assign deser_beats_o    = out_beats_q;
  assign deser_data_val_o = out_val_q;

endmodule

// File: tb/tb_deserializer_flex.sv
// Bench for deserializer_flex: three parameterisations, a vector table, directed
// multi-cycle sequences and a randomized run against a queue-based reference model.
module tb_deserializer_flex;

  logic clk;
  logic arst_n;
  int   n_cmp;
  int   n_err;

  logic        a_data, a_val, a_flush, a_dready, a_ready, a_oval;
  logic [15:0] a_out;
  logic [4:0]  a_beats;

  logic [3:0]  b_data, c_data;
  logic        b_val, b_flush, b_dready, b_ready, b_oval;
  logic        c_val, c_flush, c_dready, c_ready, c_oval;
  logic [15:0] b_out, c_out;
  logic [2:0]  b_beats, c_beats;

  deserializer_flex #(.DATA_WIDTH(16), .LANE_WIDTH(1), .MSB_FIRST(1'b1)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(a_data), .data_val_i(a_val),
    .data_ready_o(a_ready), .flush_i(a_flush), .deser_data_o(a_out),
    .deser_beats_o(a_beats), .deser_data_val_o(a_oval), .deser_data_ready_i(a_dready));

  deserializer_flex #(.DATA_WIDTH(16), .LANE_WIDTH(4), .MSB_FIRST(1'b0)) u_b (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(b_data), .data_val_i(b_val),
    .data_ready_o(b_ready), .flush_i(b_flush), .deser_data_o(b_out),
    .deser_beats_o(b_beats), .deser_data_val_o(b_oval), .deser_data_ready_i(b_dready));

  deserializer_flex #(.DATA_WIDTH(16), .LANE_WIDTH(4), .MSB_FIRST(1'b1)) u_c (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(c_data), .data_val_i(c_val),
    .data_ready_o(c_ready), .flush_i(c_flush), .deser_data_o(c_out),
    .deser_beats_o(c_beats), .deser_data_val_o(c_oval), .deser_data_ready_i(c_dready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic        v;
    logic        f;
    logic        dr;
    logic        e_rdy;
    logic        e_val;
    logic [15:0] e_data;
    logic [2:0]  e_nb;
  } vec_t;

  vec_t tbl[15];

  // Reference model for u_a: accepted beats in arrival order plus the output register.
  bit          m_bits[$];
  logic [15:0] m_data;
  logic [4:0]  m_nb;
  logic        m_val;
  logic [15:0] popped[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_data = 16'h0000;
    m_nb   = 5'd0;
    m_val  = 1'b0;
  endtask

  // One cycle of u_a: called just after a falling edge, returns at the next one.
  task automatic cyc_a(input logic d, input logic v, input logic f, input logic dr);
    logic        rdy;
    logic [15:0] w;
    a_data = d; a_val = v; a_flush = f; a_dready = dr;
    #1;
    rdy = !m_val || dr;
    chk("a_ready", a_ready, rdy);
    if (m_val && dr) popped.push_back(m_data);
    if (rdy && v) m_bits.push_back(d);
    if (rdy && m_bits.size() > 0 && (m_bits.size() == 16 || f)) begin
      w = 16'h0000;
      foreach (m_bits[k]) w[15-k] = m_bits[k];
      m_data = w;
      m_nb   = 5'(m_bits.size());
      m_val  = 1'b1;
      m_bits.delete();
    end else if (dr) begin
      m_val = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("a_val", a_oval, m_val);
    chk("a_data", a_out, m_data);
    chk("a_beats", a_beats, m_nb);
  endtask

  task automatic send_word_a(input logic [15:0] w, input logic dr);
    for (int k = 0; k < 16; k++) cyc_a(w[15-k], 1'b1, 1'b0, dr);
  endtask

  initial begin
    logic [15:0] wds[3];
    int          vhigh[$];
    int          cnt;
    int          pulses;
    logic [15:0] got_b;
    logic [2:0]  got_nb;

    n_cmp = 0; n_err = 0;
    tbl[0]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[1]  = '{4'hB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[2]  = '{4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
    tbl[3]  = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hABC0, 3'd3};
    tbl[4]  = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hABC0, 3'd3};
    tbl[5]  = '{4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'hABC0, 3'd3};
    tbl[6]  = '{4'hD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hD000, 3'd1};
    tbl[7]  = '{4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hD000, 3'd1};
    tbl[8]  = '{4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hD000, 3'd1};
    tbl[9]  = '{4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hD000, 3'd1};
    tbl[10] = '{4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hD000, 3'd1};
    tbl[11] = '{4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 3'd4};
    tbl[12] = '{4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd4};
    tbl[13] = '{4'h6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h6000, 3'd1};
    tbl[14] = '{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h6000, 3'd1};

    arst_n = 1'b0;
    a_data = 1'b0; a_val = 1'b0; a_flush = 1'b0; a_dready = 1'b1;
    b_data = 4'h0; b_val = 1'b0; b_flush = 1'b0; b_dready = 1'b1;
    c_data = 4'h0; c_val = 1'b0; c_flush = 1'b0; c_dready = 1'b1;
    model_reset();
    #12;
    chk("rst_a_val", a_oval, 1'b0);
    chk("rst_a_data", a_out, 16'h0000);
    chk("rst_a_beats", a_beats, 5'd0);
    chk("rst_b_val", b_oval, 1'b0);
    chk("rst_b_data", b_out, 16'h0000);
    chk("rst_c_val", c_oval, 1'b0);
    chk("rst_c_beats", c_beats, 3'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Vector table on the 4-bit MSB-first instance: partial flush, idle flush, pop-and-load.
    for (int i = 0; i < 15; i++) begin
      c_data = tbl[i].d; c_val = tbl[i].v; c_flush = tbl[i].f; c_dready = tbl[i].dr;
      #1;
      chk($sformatf("tbl%0d_ready", i), c_ready, tbl[i].e_rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_val", i), c_oval, tbl[i].e_val);
      chk($sformatf("tbl%0d_data", i), c_out, tbl[i].e_data);
      chk($sformatf("tbl%0d_beats", i), c_beats, tbl[i].e_nb);
    end
    c_val = 1'b0; c_flush = 1'b0; c_dready = 1'b1;

    // LSB-first 4-bit beats with random idle gaps: exactly one valid pulse.
    pulses = 0; got_b = 16'h0000; got_nb = 3'd0;
    chk("b_ready", b_ready, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      repeat ($urandom_range(0, 3)) begin
        b_val = 1'b0;
        @(negedge clk);
        if (b_oval) begin pulses++; got_b = b_out; got_nb = b_beats; end
      end
      b_data = 4'(i); b_val = 1'b1;
      @(negedge clk);
      if (b_oval) begin pulses++; got_b = b_out; got_nb = b_beats; end
    end
    b_val = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (b_oval) begin pulses++; got_b = b_out; got_nb = b_beats; end
    end
    chk("b_pulses", pulses, 1);
    chk("b_data", got_b, 16'h4321);
    chk("b_beats", got_nb, 3'd4);
    chk("b_hold", b_out, 16'h4321);

    // Single word MSB first, ready high throughout.
    send_word_a(16'hA5C3, 1'b1);
    chk("t1_val", a_oval, 1'b1);
    chk("t1_data", a_out, 16'hA5C3);
    chk("t1_beats", a_beats, 5'd16);
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_pulse", a_oval, 1'b0);

    // Backpressure: word held 20 cycles while offered beats are refused.
    popped.delete();
    send_word_a(16'h1234, 1'b0);
    for (int i = 0; i < 20; i++) cyc_a(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    chk("t4_hold_val", a_oval, 1'b1);
    chk("t4_hold_data", a_out, 16'h1234);
    send_word_a(16'h5678, 1'b1);
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_npop", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("t4_first", popped[0], 16'h1234);
      chk("t4_second", popped[1], 16'h5678);
    end

    // Back-to-back words: one valid pulse every 16 cycles.
    popped.delete();
    wds[0] = 16'h9E37; wds[1] = 16'h0F0F; wds[2] = 16'hC0DE;
    cnt = 0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 16; k++) begin
        cyc_a(wds[w][15-k], 1'b1, 1'b0, 1'b1);
        cnt++;
        if (a_oval) vhigh.push_back(cnt);
      end
    end
    cyc_a(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_pulses", vhigh.size(), 3);
    if (vhigh.size() == 3) begin
      chk("t5_gap0", vhigh[1] - vhigh[0], 16);
      chk("t5_gap1", vhigh[2] - vhigh[1], 16);
    end
    chk("t5_npop", popped.size(), 3);
    if (popped.size() == 3) chk("t5_last", popped[2], 16'hC0DE);

    // Reset mid-clock after 7 beats, then a fresh all-ones word.
    for (int k = 0; k < 7; k++) cyc_a(1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_rst_val", a_oval, 1'b0);
    chk("t6_rst_data", a_out, 16'h0000);
    chk("t6_rst_beats", a_beats, 5'd0);
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    send_word_a(16'hFFFF, 1'b1);
    chk("t6_data", a_out, 16'hFFFF);
    chk("t6_beats", a_beats, 5'd16);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/deserializer_flex.md
Name: deserializer_flex

Overview:
- Parametrised successor of the team's bit-serial deserializer.
- Collects LANE_WIDTH-bit beats into DATA_WIDTH-bit words, with selectable beat ordering (MSB-first or LSB-first).
- Supports a flush that emits a partial word, and a valid/ready handshake on the output so a downstream consumer can stall.
- Sits between a serial or narrow link receiver and word-wide datapath logic.

Parameters:
- DATA_WIDTH, 16, output word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 1, bits per input beat; DATA_WIDTH/LANE_WIDTH (BEATS) must be at least 2.
- MSB_FIRST, 1, 1 = first beat goes to the most-significant lane; 0 = first beat goes to lane 0 (least-significant).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- arst_n_i  in  1  asynchronous, active-low reset.
- data_i  in  LANE_WIDTH  input beat.
- data_val_i  in  1  beat valid.
- data_ready_o  out  1  block can accept a beat/flush this cycle.
- flush_i  in  1  close the current word early; qualified by data_ready_o.
- deser_data_o  out  DATA_WIDTH  assembled word.
- deser_beats_o  out  $clog2(BEATS+1)  number of valid beats in deser_data_o (1..BEATS).
- deser_data_val_o  out  1  output word valid.
- deser_data_ready_i  in  1  downstream accepts word.

Behaviour:
- Reset:
  - One clock, clk_i. Reset arst_n_i is asynchronous and active-low.
  - While low: accumulator = 0, beat counter = 0, deser_data_o = 0, deser_beats_o = 0, deser_data_val_o = 0.
  - Outputs go to these values immediately on assertion, independent of clk_i.
  - On release, operation begins at the first rising edge with arst_n_i high.
- Handshake:
  - data_ready_o = !deser_data_val_o || deser_data_ready_i. This is a combinational path from deser_data_ready_i.
  - A beat is accepted on a rising edge when data_val_i && data_ready_o.
  - A flush is accepted when flush_i && data_ready_o.
  - Beats and flushes offered while data_ready_o = 0 are ignored. The source must hold them.
- Beat placement (beat index k = 0..BEATS-1 within a word):
  - MSB_FIRST = 1: beat k occupies bits [DATA_WIDTH-1-k*LANE_WIDTH -: LANE_WIDTH].
  - MSB_FIRST = 0: beat k occupies bits [k*LANE_WIDTH +: LANE_WIDTH].
- Counter: increments on each accepted beat; range 0..BEATS-1.
- Word completion (accepted beat while counter == BEATS-1):
  - On the next edge, load the output register with the full word; deser_beats_o = BEATS; deser_data_val_o = 1.
  - Counter and accumulator clear to 0.
  - Latency: valid is high the cycle after the last beat is accepted.
- Flush:
  - Accepted flush together with an accepted beat: the beat is included, then the word is emitted with deser_beats_o = counter+1. If counter+1 == BEATS, this is identical to normal completion.
  - Accepted flush, no beat, counter > 0: emit a partial word with deser_beats_o = counter.
  - Accepted flush, no beat, counter == 0: no effect.
  - In a partial word, unused lanes are 0. Filled lanes keep their full-word positions per the placement rule.
- Output register:
  - deser_data_o and deser_beats_o stay stable while deser_data_val_o = 1 && deser_data_ready_i = 0.
  - When deser_data_ready_i = 1 and no new word completes in the same cycle, valid drops next cycle; data and beats hold their last value.
  - Word popped and new word completed in the same cycle: the new word loads and valid stays 1. No bubble, no loss.
- Throughput: one beat per cycle when deser_data_ready_i stays high. A word is never dropped or overwritten while unaccepted.
- data_val_i and flush_i are don't-care in the cycle reset is released. data_i is don't-care when data_val_i = 0.

Test Plan:
1. DATA_WIDTH=16, LANE_WIDTH=1, MSB_FIRST=1, deser_data_ready_i=1; 16 contiguous beats of 0xA5C3, MSB first -> one cycle after the 16th beat: deser_data_val_o=1 for 1 cycle, deser_data_o=0xA5C3, deser_beats_o=16.
2. LANE_WIDTH=4, MSB_FIRST=0; beats 0x1,0x2,0x3,0x4 with random idle gaps -> deser_data_o=0x4321, deser_beats_o=4, exactly one valid pulse.
3. LANE_WIDTH=4, MSB_FIRST=1; beats 0xA,0xB,0xC, then flush_i alone -> deser_data_o=0xABC0, deser_beats_o=3. Flush with counter==0 -> no valid.
4. Backpressure: word 0x1234 completes with deser_data_ready_i=0 -> data_ready_o=0, offered beats not counted, output held 20 cycles. Raise deser_data_ready_i with the next word streaming -> 0x1234 then 0x5678 delivered in order, no loss.
5. Back-to-back words, deser_data_ready_i=1, LANE_WIDTH=1 -> valid pulses every 16 cycles; pop-and-load cycle keeps valid high with the new word.
6. Assert arst_n_i mid-clock after 7 beats -> all outputs 0 immediately. After release, 16 fresh beats of 0xFFFF -> 0xFFFF with beats=16, no residue from the aborted word.
